// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the writeback scheduler slice.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 32;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic                 wen;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } ld_buf_t;

  function automatic logic [RF_NREGS-1:0] onehot(input logic [RF_ADDR_W-1:0] a);
    return {{(RF_NREGS-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage

// File: rtl/rf_wb_sched_if.sv
// Decode, ALU writeback, LSU response and register-file write bundle.
interface rf_wb_sched_if;
  import rf_pkg::*;

  logic                 id_valid;
  logic [RF_ADDR_W-1:0] id_rs1;
  logic [RF_ADDR_W-1:0] id_rs2;
  logic                 id_rs1_en;
  logic                 id_rs2_en;
  logic [RF_ADDR_W-1:0] id_rd;
  logic                 id_rd_en;
  logic                 id_is_load;
  logic                 stall;
  logic                 alu_wen;
  logic [RF_ADDR_W-1:0] alu_waddr;
  logic [RF_DATA_W-1:0] alu_wdata;
  logic                 lsu_rsp_valid;
  logic                 lsu_rsp_ready;
  logic [RF_ADDR_W-1:0] lsu_rsp_rd;
  logic [RF_DATA_W-1:0] lsu_rsp_data;
  logic                 rf_wen;
  logic [RF_ADDR_W-1:0] rf_waddr;
  logic [RF_DATA_W-1:0] rf_wdata;
  logic [RF_NREGS-1:0]  busy_vec;
  logic                 sb_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_rd_en, id_is_load,
    output alu_wen, alu_waddr, alu_wdata, lsu_rsp_valid, lsu_rsp_rd, lsu_rsp_data,
    input  stall, lsu_rsp_ready, rf_wen, rf_waddr, rf_wdata, busy_vec, sb_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_rd_en, id_is_load,
    input  alu_wen, alu_waddr, alu_wdata, lsu_rsp_valid, lsu_rsp_rd, lsu_rsp_data,
    output stall, lsu_rsp_ready, rf_wen, rf_waddr, rf_wdata, busy_vec, sb_err
  );

endinterface

// File: rtl/gnrl_dffl.sv
// Generic load-enabled flop with synchronous active-high reset to zero.
module gnrl_dffl #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       o_q <= '0;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Busy-register vector and outstanding-load counter; a set beats a clear on the same bit.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set_en,
  input  logic [RF_ADDR_W-1:0] i_set_addr,
  input  logic                 i_clr_en,
  input  logic [RF_ADDR_W-1:0] i_clr_addr,
  input  logic                 i_inc,
  input  logic                 i_dec,
  output logic [RF_NREGS-1:0]  o_busy_vec,
  output logic [CNT_W-1:0]     o_count
);

  logic [RF_NREGS-1:0] r_busy;
  logic [RF_NREGS-1:0] w_busy_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  // NOTE: default assignment first; a branch that skips a variable would infer a latch.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt = w_busy_nxt & ~onehot(i_clr_addr);
    if (i_set_en) w_busy_nxt = w_busy_nxt | onehot(i_set_addr);
    w_busy_nxt[0] = 1'b0;
  end

  // Decrement saturates at zero so a spurious drain cannot wrap the counter.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({i_inc, i_dec})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
      default: ;
    endcase
  end

  gnrl_dffl #(.DW(RF_NREGS)) u_busy (
    .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_busy_nxt), .o_q(r_busy)
  );

  gnrl_dffl #(.DW(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_cnt_nxt), .o_q(r_cnt)
  );

  assign o_busy_vec = r_busy;
  assign o_count    = r_cnt;

endmodule

// File: rtl/rf_wb_sched.sv
// Shares the register-file write port between ALU writeback and buffered load
// results, and raises the decode stall for scoreboard hazards and load overflow.
module rf_wb_sched
  import rf_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic         clk,
  input logic         rst,
  rf_wb_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [RF_NREGS-1:0] w_busy;
  logic [CNT_W-1:0]    w_count;
  logic                w_hz;
  logic                w_full;
  logic                w_stall;
  logic                w_issue_ld;
  logic                w_alu_wr;
  logic                w_drain;
  logic                w_drain_wr;
  logic                w_ready;
  logic                w_hs;
  logic                w_err_set;
  ld_buf_t             r_buf;
  ld_buf_t             w_buf_nxt;
  rf_wr_t              r_rf;
  rf_wr_t              w_rf_nxt;
  logic                r_err;

  assign w_hz = (bus.id_rs1_en & w_busy[bus.id_rs1]) |
                (bus.id_rs2_en & w_busy[bus.id_rs2]) |
                (bus.id_rd_en  & w_busy[bus.id_rd]);
  assign w_full     = bus.id_is_load & (w_count == MAX_CNT);
  assign w_stall    = bus.id_valid & (w_hz | w_full);
  assign w_issue_ld = bus.id_valid & ~w_stall & bus.id_is_load & bus.id_rd_en &
                      (bus.id_rd != '0);

  // ALU writeback cannot be held off, so the load buffer only drains in ALU-free cycles.
  assign w_alu_wr   = bus.alu_wen & (bus.alu_waddr != '0);
  assign w_drain    = r_buf.valid & ~w_alu_wr;
  assign w_drain_wr = w_drain & (r_buf.rd != '0);
  assign w_ready    = ~rst & (~r_buf.valid | w_drain);
  assign w_hs       = bus.lsu_rsp_valid & w_ready;
  assign w_err_set  = w_drain_wr & (~w_busy[r_buf.rd] | (w_count == '0));

  always_comb begin
    w_buf_nxt = r_buf;
    if (w_drain) w_buf_nxt.valid = 1'b0;
    if (w_hs)    w_buf_nxt = '{valid: 1'b1, rd: bus.lsu_rsp_rd, data: bus.lsu_rsp_data};
  end

  always_comb begin
    w_rf_nxt = '0;
    if (w_alu_wr)        w_rf_nxt = '{wen: 1'b1, addr: bus.alu_waddr, data: bus.alu_wdata};
    else if (w_drain_wr) w_rf_nxt = '{wen: 1'b1, addr: r_buf.rd, data: r_buf.data};
  end

  gnrl_dffl #(.DW($bits(ld_buf_t))) u_buf (
    .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_buf_nxt), .o_q(r_buf)
  );

  gnrl_dffl #(.DW($bits(rf_wr_t))) u_rf (
    .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_rf_nxt), .o_q(r_rf)
  );

  gnrl_dffl #(.DW(1)) u_err (
    .clk(clk), .rst(rst), .i_en(w_err_set), .i_d(1'b1), .o_q(r_err)
  );

  rf_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_issue_ld),
    .i_set_addr (bus.id_rd),
    .i_clr_en   (w_drain_wr),
    .i_clr_addr (r_buf.rd),
    .i_inc      (w_issue_ld),
    .i_dec      (w_drain_wr),
    .o_busy_vec (w_busy),
    .o_count    (w_count)
  );

  assign bus.stall         = w_stall;
  assign bus.lsu_rsp_ready = w_ready;
  assign bus.rf_wen        = r_rf.wen;
  assign bus.rf_waddr      = r_rf.addr;
  assign bus.rf_wdata      = r_rf.data;
  assign bus.busy_vec      = w_busy;
  assign bus.sb_err        = r_err;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed scenarios followed by random traffic checked against a rule-level model.
module tb_rf_wb_sched;
  import rf_pkg::*;

  localparam int MAXO = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_wb_sched_if bus();

  rf_wb_sched #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy[32];
  int          m_cnt;
  ent_t        m_buf[$];
  logic [4:0]  m_pend[$];
  bit          m_err;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_en = 0; bus.id_rs2_en = 0;
    bus.id_rd = 0; bus.id_rd_en = 0; bus.id_is_load = 0;
    bus.alu_wen = 0; bus.alu_waddr = 0; bus.alu_wdata = 0;
    bus.lsu_rsp_valid = 0; bus.lsu_rsp_rd = 0; bus.lsu_rsp_data = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.id_valid = 1; bus.id_is_load = 1; bus.id_rd_en = 1; bus.id_rd = rd;
    bus.id_rs1_en = 0; bus.id_rs2_en = 0;
  endtask

  task automatic lsu_rsp(input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_rsp_valid = 1; bus.lsu_rsp_rd = rd; bus.lsu_rsp_data = d;
  endtask

  task automatic check_rf(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_wen"}, 32'(bus.rf_wen), 32'd1);
    check({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(a));
    check({tag, "_wdata"}, bus.rf_wdata, d);
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_cnt = 0; m_buf.delete(); m_pend.delete(); m_err = 0; m_wen = 0;
  endtask

  task automatic rand_cycle();
    bit hz, full, exp_stall, alu_wr, drain, exp_ready, hs, iss, drain_wr, from_pend;
    ent_t head;
    logic [31:0] vec;
    idle();
    bus.id_valid   = ($urandom_range(9) < 7);
    bus.id_rs1     = 5'($urandom_range(7));
    bus.id_rs2     = 5'($urandom_range(7));
    bus.id_rd      = 5'($urandom_range(7));
    bus.id_rs1_en  = 1'($urandom);
    bus.id_rs2_en  = 1'($urandom);
    bus.id_rd_en   = 1'($urandom);
    bus.id_is_load = ($urandom_range(9) < 4);
    bus.alu_wen    = ($urandom_range(9) < 4);
    bus.alu_waddr  = 5'($urandom_range(7));
    bus.alu_wdata  = $urandom;
    from_pend = 0;
    if (m_pend.size() != 0 && $urandom_range(1) == 1) begin
      lsu_rsp(m_pend[0], $urandom);
      from_pend = 1;
    end else if ($urandom_range(31) == 0) begin
      lsu_rsp(5'($urandom), $urandom);
    end
    settle();

    hz = (bus.id_rs1_en && m_busy[bus.id_rs1]) || (bus.id_rs2_en && m_busy[bus.id_rs2]) ||
         (bus.id_rd_en && m_busy[bus.id_rd]);
    full      = bus.id_is_load && (m_cnt == MAXO);
    exp_stall = bus.id_valid && (hz || full);
    alu_wr    = bus.alu_wen && (bus.alu_waddr != 0);
    drain     = (m_buf.size() != 0) && !alu_wr;
    exp_ready = (m_buf.size() == 0) || drain;
    check("rnd_stall", 32'(bus.stall), 32'(exp_stall));
    check("rnd_ready", 32'(bus.lsu_rsp_ready), 32'(exp_ready));

    hs  = bus.lsu_rsp_valid && exp_ready;
    iss = bus.id_valid && !exp_stall && bus.id_is_load && bus.id_rd_en && (bus.id_rd != 0);

    m_wen = 0;
    drain_wr = 0;
    if (drain) begin
      head = m_buf.pop_front();
      drain_wr = (head.rd != 0);
    end
    if (alu_wr) begin
      m_wen = 1; m_waddr = bus.alu_waddr; m_wdata = bus.alu_wdata;
    end else if (drain_wr) begin
      m_wen = 1; m_waddr = head.rd; m_wdata = head.data;
    end
    if (drain_wr) begin
      if (!m_busy[head.rd] || m_cnt == 0) m_err = 1;
      m_busy[head.rd] = 0;
    end
    if (iss) begin
      m_busy[bus.id_rd] = 1;
      m_pend.push_back(bus.id_rd);
    end
    if (iss && !drain_wr) m_cnt++;
    else if (drain_wr && !iss && m_cnt > 0) m_cnt--;
    if (hs) begin
      m_buf.push_back('{rd: bus.lsu_rsp_rd, data: bus.lsu_rsp_data});
      if (from_pend) void'(m_pend.pop_front());
    end

    tick();
    check("rnd_wen", 32'(bus.rf_wen), 32'(m_wen));
    if (m_wen) begin
      check("rnd_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
      check("rnd_wdata", bus.rf_wdata, m_wdata);
    end
    for (int i = 0; i < 32; i++) vec[i] = m_busy[i];
    check("rnd_busy", bus.busy_vec, vec);
    check("rnd_err", 32'(bus.sb_err), 32'(m_err));
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    check("rst_wen", 32'(bus.rf_wen), 32'd0);
    check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_busy", bus.busy_vec, 32'd0);
    check("rst_err", 32'(bus.sb_err), 32'd0);
    check("rst_ready", 32'(bus.lsu_rsp_ready), 32'd0);
    issue(5); bus.id_rs1_en = 1; bus.id_rs1 = 5;
    settle();
    check("rst_stall", 32'(bus.stall), 32'd0);
    idle();
    rst = 0;

    // Load to x5, dependent read, response and unstall
    issue(5);
    settle();
    check("t1_issue_stall", 32'(bus.stall), 32'd0);
    check("t1_ready", 32'(bus.lsu_rsp_ready), 32'd1);
    tick();
    check("t1_busy", bus.busy_vec, 32'h20);
    idle(); bus.id_valid = 1; bus.id_rs1_en = 1; bus.id_rs1 = 5;
    lsu_rsp(5, 32'hDEADBEEF);
    settle();
    check("t1_raw_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.lsu_rsp_valid = 0;
    settle();
    check("t1_stall_buf", 32'(bus.stall), 32'd1);
    check("t1_no_wen", 32'(bus.rf_wen), 32'd0);
    tick();
    check_rf("t1_rf", 5, 32'hDEADBEEF);
    check("t1_busy_clr", bus.busy_vec, 32'h0);
    check("t1_unstall", 32'(bus.stall), 32'd0);
    idle();

    // ALU write collides with a buffered load
    issue(7);
    tick();
    idle(); lsu_rsp(7, 32'h77);
    tick();
    idle(); bus.alu_wen = 1; bus.alu_waddr = 3; bus.alu_wdata = 32'h11;
    settle();
    check("t2_ready_conflict", 32'(bus.lsu_rsp_ready), 32'd0);
    tick();
    check_rf("t2_alu", 3, 32'h11);
    check("t2_busy7", bus.busy_vec, 32'h80);
    idle();
    tick();
    check_rf("t2_load", 7, 32'h77);
    check("t2_busy_clr", bus.busy_vec, 32'h0);

    // Outstanding-load limit
    for (int r = 1; r <= 4; r++) begin
      issue(5'(r));
      settle();
      check("t3_issue", 32'(bus.stall), 32'd0);
      tick();
    end
    issue(6);
    settle();
    check("t3_full_stall", 32'(bus.stall), 32'd1);
    tick();
    check("t3_busy_full", bus.busy_vec, 32'h1E);
    lsu_rsp(1, 32'h101);
    tick();
    bus.lsu_rsp_valid = 0;
    settle();
    check("t3_still_full", 32'(bus.stall), 32'd1);
    tick();
    check_rf("t3_drain", 1, 32'h101);
    check("t3_unstall", 32'(bus.stall), 32'd0);
    tick();
    check("t3_busy_5th", bus.busy_vec, 32'h5C);
    idle();
    for (int k = 0; k < 4; k++) begin
      lsu_rsp((k == 3) ? 5'd6 : 5'(k + 2), 32'(k));
      settle();
      check("t3_cleanup_ready", 32'(bus.lsu_rsp_ready), 32'd1);
      tick();
    end
    idle();
    tick();
    tick();
    check("t3_busy_empty", bus.busy_vec, 32'h0);

    // x0 writes from every source, then a spurious response
    issue(0); bus.alu_wen = 1; bus.alu_waddr = 0; bus.alu_wdata = 32'h55;
    lsu_rsp(0, 32'h99);
    settle();
    check("t5_x0_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    check("t5_alu_x0_wen", 32'(bus.rf_wen), 32'd0);
    check("t5_ld_x0_busy", bus.busy_vec, 32'h0);
    tick();
    check("t5_rsp_x0_wen", 32'(bus.rf_wen), 32'd0);
    check("t5_rsp_x0_err", 32'(bus.sb_err), 32'd0);
    lsu_rsp(12, 32'hC0C0);
    tick();
    idle();
    tick();
    check_rf("t5_spurious", 12, 32'hC0C0);
    check("t5_err_set", 32'(bus.sb_err), 32'd1);
    tick();
    tick();
    check("t5_err_held", 32'(bus.sb_err), 32'd1);

    // Same-cycle drain and reissue of x9 with three loads in flight
    for (int r = 1; r <= 3; r++) begin
      issue(5'(r));
      tick();
    end
    idle(); lsu_rsp(9, 32'h9);
    tick();
    idle(); issue(9);
    settle();
    check("t4_issue9", 32'(bus.stall), 32'd0);
    tick();
    check("t4_busy9", bus.busy_vec, 32'h20E);
    check_rf("t4_drain9", 9, 32'h9);
    issue(4);
    settle();
    check("t4_cnt3", 32'(bus.stall), 32'd0);
    tick();
    issue(5);
    settle();
    check("t4_cnt4", 32'(bus.stall), 32'd1);
    check("t4_busy", bus.busy_vec, 32'h21E);

    // Reset with loads in flight and the buffer full
    idle(); lsu_rsp(1, 32'hAAAA);
    settle();
    check("t6_ready_pre", 32'(bus.lsu_rsp_ready), 32'd1);
    tick();
    idle();
    rst = 1;
    tick();
    check("t6_wen", 32'(bus.rf_wen), 32'd0);
    check("t6_waddr", 32'(bus.rf_waddr), 32'd0);
    check("t6_wdata", bus.rf_wdata, 32'd0);
    check("t6_busy", bus.busy_vec, 32'h0);
    check("t6_err", 32'(bus.sb_err), 32'd0);
    check("t6_ready_rst", 32'(bus.lsu_rsp_ready), 32'd0);
    rst = 0;
    issue(1); bus.id_rs1_en = 1; bus.id_rs1 = 1;
    settle();
    check("t6_ready_post", 32'(bus.lsu_rsp_ready), 32'd1);
    check("t6_stall", 32'(bus.stall), 32'd0);
    tick();
    check("t6_buf_dropped", 32'(bus.rf_wen), 32'd0);
    check("t6_busy_new", bus.busy_vec, 32'h2);

    // Random traffic against the model
    idle();
    rst = 1;
    tick();
    rst = 0;
    model_reset();
    repeat (1500) rand_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
